// File: rtl/dp_ram_port_arbiter.sv
// Round-robin arbiter sharing one RAM port between two OBI-style requesters (0: LSU, 1: host).
// Grant is combinational on req; responses return RD_LATENCY cycles after accept, no response back-pressure.
module dp_ram_port_arbiter #(
  parameter int          ADDR_WIDTH = 32,
  parameter int          RAM_AW     = 17,
  parameter int          RD_LATENCY = 2,
  parameter logic [31:0] ERR_RDATA  = 32'hDEADBEEF
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic [1:0]              req_i,
  input  logic [2*ADDR_WIDTH-1:0] addr_i,
  input  logic [1:0]              we_i,
  input  logic [7:0]              be_i,
  input  logic [63:0]             wdata_i,
  output logic [1:0]              gnt_o,
  output logic [1:0]              rvalid_o,
  output logic [31:0]             rdata_o,
  output logic                    err_o,
  output logic                    ram_en_o,
  output logic [RAM_AW-1:0]       ram_addr_o,
  output logic [3:0]              ram_we_o,
  output logic [31:0]             ram_wdata_o,
  input  logic [31:0]             ram_rdata_i
);

  typedef struct packed {
    logic vld;
    logic own;
    logic oor;
    logic we;
  } rsp_t;

  logic                  ptr_q, ptr_d;
  rsp_t                  pipe_q [RD_LATENCY];
  rsp_t                  pipe_d [RD_LATENCY];
  rsp_t                  last;
  logic                  any_gnt;
  logic                  win;
  logic [ADDR_WIDTH-1:0] win_addr;
  logic                  win_we;
  logic [3:0]            win_be;
  logic                  oor;
  logic                  unused_addr_lsb;

  // ptr_q names the requester that wins when both are requesting.
  always_comb begin
    gnt_o = 2'b00;
    win   = 1'b0;
    if (!rst_i) begin
      case (req_i)
        2'b01:   gnt_o = 2'b01;
        2'b10: begin
          gnt_o = 2'b10;
          win   = 1'b1;
        end
        2'b11: begin
          win   = ptr_q;
          gnt_o = ptr_q ? 2'b10 : 2'b01;
        end
        default: gnt_o = 2'b00;
      endcase
    end
  end

  assign any_gnt         = |gnt_o;
  assign win_addr        = win ? addr_i[2*ADDR_WIDTH-1:ADDR_WIDTH] : addr_i[ADDR_WIDTH-1:0];
  assign win_we          = win ? we_i[1] : we_i[0];
  assign win_be          = win ? be_i[7:4] : be_i[3:0];
  assign oor             = |win_addr[ADDR_WIDTH-1:RAM_AW+2];
  assign unused_addr_lsb = ^win_addr[1:0];

  assign ram_en_o    = any_gnt;
  assign ram_addr_o  = win_addr[RAM_AW+1:2];
  assign ram_wdata_o = win ? wdata_i[63:32] : wdata_i[31:0];
  assign ram_we_o    = (any_gnt && !oor) ? (win_be & {4{win_we}}) : 4'b0000;

  always_comb begin
    ptr_d     = any_gnt ? ~win : ptr_q;
    pipe_d[0] = '{vld: any_gnt, own: win, oor: oor, we: win_we};
    for (int i = 1; i < RD_LATENCY; i++) begin
      pipe_d[i] = pipe_q[i-1];
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ptr_q <= 1'b0;
      for (int i = 0; i < RD_LATENCY; i++) begin
        pipe_q[i] <= '0;
      end
    end else begin
      ptr_q <= ptr_d;
      for (int i = 0; i < RD_LATENCY; i++) begin
        pipe_q[i] <= pipe_d[i];
      end
    end
  end

  // Response comes from the last stage, aligned with RAM read data.
  always_comb begin
    last     = pipe_q[RD_LATENCY-1];
    rvalid_o = 2'b00;
    rdata_o  = 32'h0;
    err_o    = 1'b0;
    if (last.vld && !rst_i) begin
      rvalid_o = last.own ? 2'b10 : 2'b01;
      err_o    = last.oor;
      if (last.we)       rdata_o = 32'h0;
      else if (last.oor) rdata_o = ERR_RDATA;
      else               rdata_o = ram_rdata_i;
    end
  end

endmodule

// File: tb/tb_dp_ram_port_arbiter.sv
// Directed bench: RD_LATENCY=2 instance for most scenarios, RD_LATENCY=1 instance for pipelined reads.
module tb_dp_ram_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  always #5 clk = ~clk;

  // Instance A: RD_LATENCY = 2
  logic [1:0]  req_a, we_a, gnt_a, rvalid_a;
  logic [63:0] addr_a, wdata_a;
  logic [7:0]  be_a;
  logic [31:0] rdata_a, ram_wdata_a, ram_rdata_a;
  logic        err_a, ram_en_a;
  logic [16:0] ram_addr_a;
  logic [3:0]  ram_we_a;

  // Instance B: RD_LATENCY = 1
  logic [1:0]  req_b, we_b, gnt_b, rvalid_b;
  logic [63:0] addr_b, wdata_b;
  logic [7:0]  be_b;
  logic [31:0] rdata_b, ram_wdata_b, ram_rdata_b;
  logic        err_b, ram_en_b;
  logic [16:0] ram_addr_b;
  logic [3:0]  ram_we_b;

  dp_ram_port_arbiter #(.RD_LATENCY(2)) u_dut_a (
    .clk_i(clk), .rst_i(rst), .req_i(req_a), .addr_i(addr_a), .we_i(we_a), .be_i(be_a),
    .wdata_i(wdata_a), .gnt_o(gnt_a), .rvalid_o(rvalid_a), .rdata_o(rdata_a), .err_o(err_a),
    .ram_en_o(ram_en_a), .ram_addr_o(ram_addr_a), .ram_we_o(ram_we_a),
    .ram_wdata_o(ram_wdata_a), .ram_rdata_i(ram_rdata_a)
  );

  dp_ram_port_arbiter #(.RD_LATENCY(1)) u_dut_b (
    .clk_i(clk), .rst_i(rst), .req_i(req_b), .addr_i(addr_b), .we_i(we_b), .be_i(be_b),
    .wdata_i(wdata_b), .gnt_o(gnt_b), .rvalid_o(rvalid_b), .rdata_o(rdata_b), .err_o(err_b),
    .ram_en_o(ram_en_b), .ram_addr_o(ram_addr_b), .ram_we_o(ram_we_b),
    .ram_wdata_o(ram_wdata_b), .ram_rdata_i(ram_rdata_b)
  );

  // RAM models, preloaded with word i = 0x5A000000 | i
  logic [31:0] mem_a [1024];
  logic [31:0] mem_b [1024];
  logic [31:0] rd_a_p1, rd_a_p2, rd_b_p1;

  always @(posedge clk) begin
    if (ram_en_a) begin
      rd_a_p1 <= mem_a[ram_addr_a[9:0]];
      for (int k = 0; k < 4; k++)
        if (ram_we_a[k]) mem_a[ram_addr_a[9:0]][8*k +: 8] <= ram_wdata_a[8*k +: 8];
    end
    rd_a_p2 <= rd_a_p1;
  end

  always @(posedge clk) begin
    if (ram_en_b) begin
      rd_b_p1 <= mem_b[ram_addr_b[9:0]];
      for (int k = 0; k < 4; k++)
        if (ram_we_b[k]) mem_b[ram_addr_b[9:0]][8*k +: 8] <= ram_wdata_b[8*k +: 8];
    end
  end

  assign ram_rdata_a = rd_a_p2;
  assign ram_rdata_b = rd_b_p1;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_a(input int n, input logic we, input logic [31:0] addr,
                       input logic [3:0] be, input logic [31:0] wd);
    we_a[n]            = we;
    addr_a[n*32 +: 32] = addr;
    be_a[n*4 +: 4]     = be;
    wdata_a[n*32 +: 32] = wd;
  endtask

  logic [1:0]  rr_gnt [4];
  logic [31:0] rr_dat [4];

  initial begin
    for (int i = 0; i < 1024; i++) begin
      mem_a[i] = 32'h5A00_0000 | i;
      mem_b[i] = 32'h5A00_0000 | i;
    end
    rd_a_p1 = '0; rd_a_p2 = '0; rd_b_p1 = '0;
    rst = 1'b1;
    req_a = '0; we_a = '0; addr_a = '0; be_a = '0; wdata_a = '0;
    req_b = '0; we_b = '0; addr_b = '0; be_b = '0; wdata_b = '0;
    step();
    step();

    // Reset state, with both requesting
    req_a = 2'b11;
    #1;
    check("rst_gnt", gnt_a, 2'b00);
    check("rst_ram_en", ram_en_a, 1'b0);
    check("rst_ram_we", ram_we_a, 4'h0);
    check("rst_rvalid", rvalid_a, 2'b00);
    check("rst_rdata", rdata_a, 32'h0);
    check("rst_err", err_a, 1'b0);
    req_a = 2'b00;
    rst = 1'b0;
    step();

    // Single read from requester 0 at 0x100
    set_a(0, 1'b0, 32'h100, 4'hF, 32'h0);
    req_a = 2'b01;
    #1;
    check("rd_gnt", gnt_a, 2'b01);
    check("rd_ram_en", ram_en_a, 1'b1);
    check("rd_ram_addr", ram_addr_a, 17'h40);
    check("rd_ram_we", ram_we_a, 4'h0);
    step();
    req_a = 2'b00;
    #1;
    check("rd_rvalid_early", rvalid_a, 2'b00);
    step();
    #1;
    check("rd_rvalid", rvalid_a, 2'b01);
    check("rd_rdata", rdata_a, 32'h5A000040);
    check("rd_err", err_a, 1'b0);
    step();
    #1;
    check("rd_rvalid_end", rvalid_a, 2'b00);

    // Accept a read (pointer moves to 1), then reset on the next edge
    req_a = 2'b01;
    #1;
    check("mid_gnt", gnt_a, 2'b01);
    step();
    rst = 1'b1;
    req_a = 2'b11;
    #1;
    check("mid_gnt_in_rst", gnt_a, 2'b00);
    check("mid_ram_en_in_rst", ram_en_a, 1'b0);
    step();
    #1;
    check("mid_rvalid_1", rvalid_a, 2'b00);
    step();
    #1;
    check("mid_rvalid_2", rvalid_a, 2'b00);
    rst = 1'b0;

    // Both requesting reads for 4 cycles; pointer restarts at 0
    set_a(0, 1'b0, 32'h0, 4'hF, 32'h0);
    set_a(1, 1'b0, 32'h4, 4'hF, 32'h0);
    rr_gnt[0] = 2'b01; rr_gnt[1] = 2'b10; rr_gnt[2] = 2'b01; rr_gnt[3] = 2'b10;
    rr_dat[0] = 32'h5A000000; rr_dat[1] = 32'h5A000001;
    rr_dat[2] = 32'h5A000000; rr_dat[3] = 32'h5A000001;
    req_a = 2'b11;
    for (int i = 0; i < 4; i++) begin
      #1;
      check($sformatf("rr_gnt%0d", i), gnt_a, rr_gnt[i]);
      if (i >= 2) begin
        check($sformatf("rr_rvalid%0d", i-2), rvalid_a, rr_gnt[i-2]);
        check($sformatf("rr_rdata%0d", i-2), rdata_a, rr_dat[i-2]);
      end
      step();
    end
    req_a = 2'b00;
    for (int i = 2; i < 4; i++) begin
      #1;
      check($sformatf("rr_rvalid%0d", i), rvalid_a, rr_gnt[i]);
      check($sformatf("rr_rdata%0d", i), rdata_a, rr_dat[i]);
      step();
    end
    #1;
    check("rr_rvalid_end", rvalid_a, 2'b00);

    // Partial write by requester 1, then read back by requester 0
    set_a(1, 1'b1, 32'h200, 4'b0011, 32'hCAFEF00D);
    req_a = 2'b10;
    #1;
    check("wr_gnt", gnt_a, 2'b10);
    check("wr_ram_we", ram_we_a, 4'b0011);
    check("wr_ram_wdata", ram_wdata_a, 32'hCAFEF00D);
    check("wr_ram_addr", ram_addr_a, 17'h80);
    step();
    set_a(0, 1'b0, 32'h200, 4'hF, 32'h0);
    req_a = 2'b01;
    #1;
    check("wrrd_gnt", gnt_a, 2'b01);
    check("wrrd_ram_we", ram_we_a, 4'h0);
    step();
    req_a = 2'b00;
    #1;
    check("wr_rvalid", rvalid_a, 2'b10);
    check("wr_rdata", rdata_a, 32'h0);
    check("wr_err", err_a, 1'b0);
    step();
    #1;
    check("wrrd_rvalid", rvalid_a, 2'b01);
    check("wrrd_rdata", rdata_a, 32'h5A00F00D);
    step();

    // Out-of-range read
    set_a(0, 1'b0, 32'h0008_0000, 4'hF, 32'h0);
    req_a = 2'b01;
    #1;
    check("oor_gnt", gnt_a, 2'b01);
    check("oor_ram_en", ram_en_a, 1'b1);
    check("oor_ram_we", ram_we_a, 4'h0);
    step();
    req_a = 2'b00;
    step();
    #1;
    check("oor_rvalid", rvalid_a, 2'b01);
    check("oor_rdata", rdata_a, 32'hDEADBEEF);
    check("oor_err", err_a, 1'b1);

    // Out-of-range write aliasing word 0x40, then read word 0x40
    set_a(0, 1'b1, 32'h0008_0100, 4'hF, 32'h12345678);
    req_a = 2'b01;
    #1;
    check("oorw_gnt", gnt_a, 2'b01);
    check("oorw_ram_we", ram_we_a, 4'h0);
    step();
    set_a(0, 1'b0, 32'h100, 4'hF, 32'h0);
    #1;
    step();
    req_a = 2'b00;
    #1;
    check("oorw_rvalid", rvalid_a, 2'b01);
    check("oorw_rdata", rdata_a, 32'h0);
    check("oorw_err", err_a, 1'b1);
    step();
    #1;
    check("oorw_chk_rvalid", rvalid_a, 2'b01);
    check("oorw_chk_rdata", rdata_a, 32'h5A000040);
    check("oorw_chk_err", err_a, 1'b0);

    // RD_LATENCY=1: back-to-back reads at 0x0, 0x4, 0x8
    addr_b[31:0] = 32'h0;
    req_b = 2'b01;
    #1;
    check("l1_gnt0", gnt_b, 2'b01);
    step();
    addr_b[31:0] = 32'h4;
    #1;
    check("l1_gnt1", gnt_b, 2'b01);
    check("l1_rvalid0", rvalid_b, 2'b01);
    check("l1_rdata0", rdata_b, 32'h5A000000);
    step();
    addr_b[31:0] = 32'h8;
    #1;
    check("l1_rvalid1", rvalid_b, 2'b01);
    check("l1_rdata1", rdata_b, 32'h5A000001);
    step();
    req_b = 2'b00;
    #1;
    check("l1_rvalid2", rvalid_b, 2'b01);
    check("l1_rdata2", rdata_b, 32'h5A000002);
    step();
    #1;
    check("l1_rvalid_end", rvalid_b, 2'b00);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
